// File: rtl/generatore_scansione_if.sv
`default_nettype none
// ============================================================================
// Module      : generatore_scansione_if
// Description : Coordinate/sync bundle between the raster-scan generator and
//               the shape hit-test consumers.
// Revision    : 1.0 - initial release
// ============================================================================
interface generatore_scansione_if;
    logic        CE;
    logic [10:0] X_CONTROLLO;
    logic [10:0] Y_CONTROLLO;
    logic        HSYNC;
    logic        VSYNC;
    logic        ATTIVO;
    logic        FINE_QUADRO;
    logic [7:0]  QUADRI;

    modport master (
        input  CE,
        output X_CONTROLLO, Y_CONTROLLO, HSYNC, VSYNC, ATTIVO, FINE_QUADRO, QUADRI
    );

    modport slave (
        output CE,
        input  X_CONTROLLO, Y_CONTROLLO, HSYNC, VSYNC, ATTIVO, FINE_QUADRO, QUADRI
    );
endinterface
`default_nettype wire

// File: rtl/generatore_scansione.sv
`default_nettype none
// ============================================================================
// Module      : generatore_scansione
// Description : Raster-scan timing generator: pixel coordinates, syncs,
//               active-video flag, end-of-frame pulse and frame counter.
// Revision    : 1.0 - initial release
// ============================================================================
module generatore_scansione #(
    parameter int unsigned H_VIS    = 1280,
    parameter int unsigned H_FP     = 48,
    parameter int unsigned H_SYNC   = 112,
    parameter int unsigned H_BP     = 248,
    parameter int unsigned V_VIS    = 1024,
    parameter int unsigned V_FP     = 1,
    parameter int unsigned V_SYNC   = 3,
    parameter int unsigned V_BP     = 38,
    parameter bit          SYNC_POL = 1'b1
) (
    input  wire logic                  CLK,
    input  wire logic                  RST_N,
    generatore_scansione_if.master     scan
);

    localparam int unsigned H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

    // Decode limits are 12 bits wide so a sync window ending exactly at 2048
    // still compares correctly against the 11-bit counters.
    localparam logic [11:0] C_H_LAST  = 12'(H_TOT - 1);
    localparam logic [11:0] C_H_VIS   = 12'(H_VIS);
    localparam logic [11:0] C_HS_BEG  = 12'(H_VIS + H_FP);
    localparam logic [11:0] C_HS_END  = 12'(H_VIS + H_FP + H_SYNC);
    localparam logic [11:0] C_V_LAST  = 12'(V_TOT - 1);
    localparam logic [11:0] C_V_VIS   = 12'(V_VIS);
    localparam logic [11:0] C_VS_BEG  = 12'(V_VIS + V_FP);
    localparam logic [11:0] C_VS_END  = 12'(V_VIS + V_FP + V_SYNC);

    logic [10:0] hc_q, hc_d;
    logic [10:0] vc_q, vc_d;
    logic [10:0] x_q, x_d;
    logic [10:0] y_q, y_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        attivo_q, attivo_d;
    logic        fine_q, fine_d;
    logic [7:0]  quadri_q, quadri_d;

    logic [11:0] w_hc;
    logic [11:0] w_vc;
    logic        w_h_last;
    logic        w_v_last;

    assign w_hc     = {1'b0, hc_q};
    assign w_vc     = {1'b0, vc_q};
    assign w_h_last = (w_hc == C_H_LAST);
    assign w_v_last = (w_vc == C_V_LAST);

    always_comb begin
        hc_d     = hc_q;
        vc_d     = vc_q;
        x_d      = x_q;
        y_d      = y_q;
        hsync_d  = hsync_q;
        vsync_d  = vsync_q;
        attivo_d = attivo_q;
        fine_d   = 1'b0;
        quadri_d = quadri_q;

        if (scan.CE) begin
            if (w_h_last) begin
                hc_d = '0;
                vc_d = w_v_last ? 11'd0 : vc_q + 11'd1;
            end else begin
                hc_d = hc_q + 11'd1;
            end

            // Outputs reflect the counters as they were before this edge.
            x_d      = hc_q;
            y_d      = vc_q;
            attivo_d = (w_hc < C_H_VIS) && (w_vc < C_V_VIS);
            hsync_d  = ((w_hc >= C_HS_BEG) && (w_hc < C_HS_END)) ? SYNC_POL : ~SYNC_POL;
            vsync_d  = ((w_vc >= C_VS_BEG) && (w_vc < C_VS_END)) ? SYNC_POL : ~SYNC_POL;
            fine_d   = w_h_last && w_v_last;
            if (fine_d) begin
                quadri_d = quadri_q + 8'd1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            hc_q     <= '0;
            vc_q     <= '0;
            x_q      <= '0;
            y_q      <= '0;
            hsync_q  <= ~SYNC_POL;
            vsync_q  <= ~SYNC_POL;
            attivo_q <= 1'b0;
            fine_q   <= 1'b0;
            quadri_q <= '0;
        end else begin
            hc_q     <= hc_d;
            vc_q     <= vc_d;
            x_q      <= x_d;
            y_q      <= y_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            attivo_q <= attivo_d;
            fine_q   <= fine_d;
            quadri_q <= quadri_d;
        end
    end

    assign scan.X_CONTROLLO = x_q;
    assign scan.Y_CONTROLLO = y_q;
    assign scan.HSYNC       = hsync_q;
    assign scan.VSYNC       = vsync_q;
    assign scan.ATTIVO      = attivo_q;
    assign scan.FINE_QUADRO = fine_q;
    assign scan.QUADRI      = quadri_q;

endmodule
`default_nettype wire

// File: tb/tb_generatore_scansione.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_generatore_scansione
// Description : Randomised CE/reset bench for generatore_scansione against an
//               arithmetic model (default, small and inverted-polarity builds).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_generatore_scansione;

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic        hs;
        logic        vs;
        logic        att;
        logic        fine;
        logic [7:0]  q;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        ce;
    int unsigned k;
    bit          last_en;
    int unsigned n_checks;
    int unsigned n_err;

    generatore_scansione_if if_def ();
    generatore_scansione_if if_small ();
    generatore_scansione_if if_neg ();

    assign if_def.CE   = ce;
    assign if_small.CE = ce;
    assign if_neg.CE   = ce;

    generatore_scansione u_dut_def (
        .CLK   (clk),
        .RST_N (rst_n),
        .scan  (if_def)
    );

    generatore_scansione #(
        .H_VIS(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_VIS(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b1)
    ) u_dut_small (
        .CLK   (clk),
        .RST_N (rst_n),
        .scan  (if_small)
    );

    generatore_scansione #(
        .H_VIS(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_VIS(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b0)
    ) u_dut_neg (
        .CLK   (clk),
        .RST_N (rst_n),
        .scan  (if_neg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // k = enabled edges since reset; the registered outputs then show pixel k-1
    // of an endless scan, with frame count = completed frames mod 256.
    function automatic exp_t model(input int unsigned kk, input bit en,
                                   input int unsigned hv, input int unsigned hf,
                                   input int unsigned hs, input int unsigned hb,
                                   input int unsigned vv, input int unsigned vf,
                                   input int unsigned vs, input int unsigned vb,
                                   input bit pol);
        exp_t e;
        int unsigned ht, vt, fr, p, px, ln;
        ht = hv + hf + hs + hb;
        vt = vv + vf + vs + vb;
        fr = ht * vt;
        if (kk == 0) begin
            e = '{x: 11'd0, y: 11'd0, hs: ~pol, vs: ~pol, att: 1'b0, fine: 1'b0, q: 8'd0};
            return e;
        end
        p  = kk - 1;
        px = p % ht;
        ln = (p / ht) % vt;
        e.x    = 11'(px);
        e.y    = 11'(ln);
        e.att  = (px < hv) && (ln < vv);
        e.hs   = (px >= hv + hf && px < hv + hf + hs) ? pol : ~pol;
        e.vs   = (ln >= vv + vf && ln < vv + vf + vs) ? pol : ~pol;
        e.fine = en && ((p % fr) == fr - 1);
        e.q    = 8'(((p + 1) / fr) % 256);
        return e;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (k=%0d t=%0t)", tag, obs, expv, k, $time);
        end
    endtask

    task automatic check_outs(input string nm, input exp_t e,
                              input logic [10:0] x, input logic [10:0] y,
                              input logic hs, input logic vs, input logic att,
                              input logic fine, input logic [7:0] q);
        check_eq({nm, ".X"},      32'(x),    32'(e.x));
        check_eq({nm, ".Y"},      32'(y),    32'(e.y));
        check_eq({nm, ".HSYNC"},  32'(hs),   32'(e.hs));
        check_eq({nm, ".VSYNC"},  32'(vs),   32'(e.vs));
        check_eq({nm, ".ATTIVO"}, 32'(att),  32'(e.att));
        check_eq({nm, ".FINE"},   32'(fine), 32'(e.fine));
        check_eq({nm, ".QUADRI"}, 32'(q),    32'(e.q));
    endtask

    task automatic check_all();
        check_outs("def", model(k, last_en, 1280, 48, 112, 248, 1024, 1, 3, 38, 1'b1),
                   if_def.X_CONTROLLO, if_def.Y_CONTROLLO, if_def.HSYNC, if_def.VSYNC,
                   if_def.ATTIVO, if_def.FINE_QUADRO, if_def.QUADRI);
        check_outs("small", model(k, last_en, 8, 2, 2, 2, 6, 1, 2, 1, 1'b1),
                   if_small.X_CONTROLLO, if_small.Y_CONTROLLO, if_small.HSYNC, if_small.VSYNC,
                   if_small.ATTIVO, if_small.FINE_QUADRO, if_small.QUADRI);
        check_outs("neg", model(k, last_en, 8, 2, 2, 2, 6, 1, 2, 1, 1'b0),
                   if_neg.X_CONTROLLO, if_neg.Y_CONTROLLO, if_neg.HSYNC, if_neg.VSYNC,
                   if_neg.ATTIVO, if_neg.FINE_QUADRO, if_neg.QUADRI);
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step(input bit c);
        ce = c;
        @(posedge clk);
        last_en = rst_n && c;
        if (last_en) k++;
        @(negedge clk);
        check_all();
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned cyc;
        n_checks = 0;
        n_err    = 0;
        k        = 0;
        last_en  = 1'b0;
        rst_n    = 1'b0;
        ce       = 1'b0;

        @(negedge clk);
        repeat (3) step(1'b1);
        rst_n = 1'b1;

        // Three full default lines: HSYNC window, blanking and line wrap.
        repeat (3 * 1688 + 10) step(1'b1);

        step(1'b1); step(1'b0); step(1'b0); step(1'b1);

        // Stop CE right after the small build's frame-end edge.
        cyc = 0;
        while ((k % 140) != 139 && cyc < 200) begin
            step(1'b1);
            cyc++;
        end
        step(1'b1);
        repeat (4) step(1'b0);
        step(1'b1);

        // Asynchronous reset between edges, mid-line and mid-frame.
        repeat (57) step(1'b1);
        #2;
        rst_n   = 1'b0;
        k       = 0;
        last_en = 1'b0;
        #1;
        check_all();
        repeat (3) step(1'b1);
        rst_n = 1'b1;
        step(1'b1);

        // Random CE until the small frame counter has wrapped past 255.
        cyc = 0;
        while (k < 258 * 140 && cyc < 80000) begin
            step($urandom_range(0, 7) != 0);
            cyc++;
        end
        check_eq("random_phase_done", 32'(k >= 258 * 140), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
